// File: rtl/rob_mc_if.sv
// Handshake and data bundle between rename, writeback, commit and the reorder buffer.
// The ROB takes the slave side. Rename, writeback and commit logic drive the master side.
interface rob_mc_if #(
    parameter int ROB_SIZE  = 16,
    parameter int ARCH_BITS = 5,
    parameter int PHYS_BITS = 6,
    parameter int WB_PORTS  = 2,
    parameter int COMMIT_W  = 2
);
    localparam int ROB_BITS = $clog2(ROB_SIZE);

    logic                                 flush;
    logic [ROB_BITS-1:0]                  flush_idx;

    logic                                 alloc_valid;
    logic                                 alloc_ready;
    logic                                 alloc_has_rd;
    logic [ARCH_BITS-1:0]                 alloc_rd_arch;
    logic [PHYS_BITS-1:0]                 alloc_rd_phys;
    logic [PHYS_BITS-1:0]                 alloc_old_phys;
    logic [ROB_BITS-1:0]                  alloc_idx;

    logic [WB_PORTS-1:0]                  wb_en;
    logic [WB_PORTS-1:0][ROB_BITS-1:0]    wb_idx;

    logic                                 commit_stall;
    logic [COMMIT_W-1:0]                  commit_valid;
    logic [COMMIT_W-1:0]                  commit_has_rd;
    logic [COMMIT_W-1:0][ARCH_BITS-1:0]   commit_rd_arch;
    logic [COMMIT_W-1:0][PHYS_BITS-1:0]   commit_rd_phys;
    logic [COMMIT_W-1:0][PHYS_BITS-1:0]   free_phys;
    logic [COMMIT_W-1:0][ROB_BITS-1:0]    commit_idx;

    logic [ROB_BITS:0]                    count;
    logic                                 full;
    logic                                 empty;

    modport slave (
        input  flush, flush_idx,
        input  alloc_valid, alloc_has_rd, alloc_rd_arch,
        input  alloc_rd_phys, alloc_old_phys,
        input  wb_en, wb_idx, commit_stall,
        output alloc_ready, alloc_idx,
        output commit_valid, commit_has_rd, commit_rd_arch,
        output commit_rd_phys, free_phys, commit_idx,
        output count, full, empty
    );

    modport master (
        output flush, flush_idx,
        output alloc_valid, alloc_has_rd, alloc_rd_arch,
        output alloc_rd_phys, alloc_old_phys,
        output wb_en, wb_idx, commit_stall,
        input  alloc_ready, alloc_idx,
        input  commit_valid, commit_has_rd, commit_rd_arch,
        input  commit_rd_phys, free_phys, commit_idx,
        input  count, full, empty
    );
endinterface

// File: rtl/rob_mc.sv
// Reorder buffer: one alloc per cycle, WB_PORTS done-markers, up to COMMIT_W
// in-order retirements per cycle, and flush rollback of the tail.
module rob_mc #(
    parameter int ROB_SIZE  = 16,
    parameter int ARCH_BITS = 5,
    parameter int PHYS_BITS = 6,
    parameter int WB_PORTS  = 2,
    parameter int COMMIT_W  = 2
) (
    input  logic      clk,
    input  logic      rst,
    rob_mc_if.slave   bus
);
    localparam int ROB_BITS = $clog2(ROB_SIZE);

    typedef logic [ROB_BITS-1:0] idx_t;
    typedef logic [ROB_BITS:0]   cnt_t;

    typedef struct packed {
        logic                 valid;
        logic                 done;
        logic                 has_rd;
        logic [ARCH_BITS-1:0] rd_arch;
        logic [PHYS_BITS-1:0] rd_phys;
        logic [PHYS_BITS-1:0] old_phys;
    } ent_t;

    ent_t rob_q [ROB_SIZE];
    ent_t rob_d [ROB_SIZE];

    idx_t head_q, head_d;
    idx_t tail_q, tail_d;
    cnt_t count_q, count_d;

    logic [COMMIT_W-1:0] cvalid;
    cnt_t                ncommit;
    logic                full;
    logic                alloc_fire;
    cnt_t                keep;
    cnt_t                squash;

    assign full            = (count_q == cnt_t'(ROB_SIZE));
    assign bus.full        = full;
    assign bus.empty       = (count_q == '0);
    assign bus.count       = count_q;
    assign bus.alloc_ready = !full;
    assign bus.alloc_idx   = tail_q;
    assign bus.commit_valid = cvalid;

    // Space freed by this cycle's commits is not offered to alloc.
    assign alloc_fire = bus.alloc_valid && !full && !bus.flush;

    // Entries kept by a flush are those between head and flush_idx.
    assign keep   = cnt_t'(idx_t'(bus.flush_idx - head_q));
    assign squash = count_q - keep;

    for (genvar g = 0; g < COMMIT_W; g++) begin : g_slot
        idx_t s;
        assign s = head_q + idx_t'(g);
        assign bus.commit_idx[g]     = s;
        assign bus.commit_has_rd[g]  = rob_q[s].has_rd;
        assign bus.commit_rd_arch[g] = rob_q[s].rd_arch;
        assign bus.commit_rd_phys[g] = rob_q[s].rd_phys;
        assign bus.free_phys[g]      = rob_q[s].old_phys;
    end

    always_comb begin : commit_sel
        logic run;
        idx_t slot;
        cvalid  = '0;
        ncommit = '0;
        slot    = head_q;
        run     = !bus.commit_stall && !bus.flush;
        for (int i = 0; i < COMMIT_W; i++) begin
            slot = head_q + idx_t'(i);
            if (run && (cnt_t'(i) < count_q) &&
                rob_q[slot].valid && rob_q[slot].done) begin
                cvalid[i] = 1'b1;
                ncommit   = ncommit + cnt_t'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    always_comb begin : next_state
        idx_t slot;
        idx_t off;
        slot    = head_q;
        off     = '0;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int j = 0; j < ROB_SIZE; j++) begin
            rob_d[j] = rob_q[j];
        end
        if (bus.flush) begin
            for (int j = 0; j < ROB_SIZE; j++) begin
                off = idx_t'(j) - bus.flush_idx;
                if (cnt_t'(off) < squash) begin
                    rob_d[j].valid = 1'b0;
                    rob_d[j].done  = 1'b0;
                end
            end
            tail_d  = bus.flush_idx;
            count_d = keep;
        end else begin
            for (int p = 0; p < WB_PORTS; p++) begin
                if (bus.wb_en[p] && rob_q[bus.wb_idx[p]].valid) begin
                    rob_d[bus.wb_idx[p]].done = 1'b1;
                end
            end
            for (int i = 0; i < COMMIT_W; i++) begin
                slot = head_q + idx_t'(i);
                if (cvalid[i]) begin
                    rob_d[slot].valid = 1'b0;
                    rob_d[slot].done  = 1'b0;
                end
            end
            if (alloc_fire) begin
                rob_d[tail_q] = '{
                    valid:    1'b1,
                    done:     1'b0,
                    has_rd:   bus.alloc_has_rd,
                    rd_arch:  bus.alloc_rd_arch,
                    rd_phys:  bus.alloc_rd_phys,
                    old_phys: bus.alloc_old_phys
                };
            end
            head_d  = head_q + idx_t'(ncommit);
            tail_d  = tail_q + idx_t'(alloc_fire);
            count_d = count_q + cnt_t'(alloc_fire) - ncommit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int j = 0; j < ROB_SIZE; j++) begin
                rob_q[j] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int j = 0; j < ROB_SIZE; j++) begin
                rob_q[j] <= rob_d[j];
            end
        end
    end
endmodule

// File: tb/tb_rob_mc.sv
// Directed bench for rob_mc with an in-order queue model of the buffer
// and a per-cycle compare process.
module tb_rob_mc;
    localparam int RS = 16;
    localparam int CW = 2;

    logic clk;
    logic rst;

    rob_mc_if #(.ROB_SIZE(RS), .ARCH_BITS(5), .PHYS_BITS(6),
                .WB_PORTS(2), .COMMIT_W(CW)) bus ();

    rob_mc #(.ROB_SIZE(RS), .ARCH_BITS(5), .PHYS_BITS(6),
             .WB_PORTS(2), .COMMIT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // The model is the ordered list of live instructions, oldest first.
    typedef struct {
        int idx;
        bit done;
        bit has_rd;
        int arch;
        int phys;
        int old;
    } me_t;

    me_t q[$];
    int  m_head = 0;

    initial begin : compare
        me_t nq[$];
        me_t e;
        int  nh, n, keep;
        logic [CW-1:0] ecv;
        forever begin
            @(negedge clk);
            n = 0;
            if (!bus.commit_stall && !bus.flush) begin
                while (n < CW && n < q.size() && q[n].done) n++;
            end
            ecv = CW'((1 << n) - 1);
            if (chk_en) begin
                chk("count", 32'(bus.count), 32'(q.size()));
                chk("full", 32'(bus.full), 32'(q.size() == RS));
                chk("empty", 32'(bus.empty), 32'(q.size() == 0));
                chk("alloc_ready", 32'(bus.alloc_ready), 32'(q.size() < RS));
                chk("alloc_idx", 32'(bus.alloc_idx),
                    32'((m_head + q.size()) % RS));
                chk("commit_valid", 32'(bus.commit_valid), 32'(ecv));
                for (int i = 0; i < n; i++) begin
                    chk("commit_idx", 32'(bus.commit_idx[i]), 32'(q[i].idx));
                    chk("commit_has_rd", 32'(bus.commit_has_rd[i]),
                        32'(q[i].has_rd));
                    chk("commit_rd_arch", 32'(bus.commit_rd_arch[i]),
                        32'(q[i].arch));
                    chk("commit_rd_phys", 32'(bus.commit_rd_phys[i]),
                        32'(q[i].phys));
                    chk("free_phys", 32'(bus.free_phys[i]), 32'(q[i].old));
                end
            end
            nq = q;
            nh = m_head;
            if (rst) begin
                nq.delete();
                nh = 0;
            end else if (bus.flush) begin
                keep = (int'(bus.flush_idx) - m_head + RS) % RS;
                while (nq.size() > keep) void'(nq.pop_back());
            end else begin
                for (int i = 0; i < n; i++) void'(nq.pop_front());
                nh = (m_head + n) % RS;
                for (int p = 0; p < 2; p++) begin
                    if (bus.wb_en[p]) begin
                        foreach (nq[k]) begin
                            if (nq[k].idx == int'(bus.wb_idx[p])) nq[k].done = 1'b1;
                        end
                    end
                end
                if (bus.alloc_valid && q.size() < RS) begin
                    e.idx    = (m_head + q.size()) % RS;
                    e.done   = 1'b0;
                    e.has_rd = bus.alloc_has_rd;
                    e.arch   = int'(bus.alloc_rd_arch);
                    e.phys   = int'(bus.alloc_rd_phys);
                    e.old    = int'(bus.alloc_old_phys);
                    nq.push_back(e);
                end
            end
            @(posedge clk);
            q      = nq;
            m_head = nh;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush          = 1'b0;
        bus.flush_idx      = '0;
        bus.alloc_valid    = 1'b0;
        bus.alloc_has_rd   = 1'b0;
        bus.alloc_rd_arch  = '0;
        bus.alloc_rd_phys  = '0;
        bus.alloc_old_phys = '0;
        bus.wb_en          = '0;
        bus.wb_idx         = '0;
        bus.commit_stall   = 1'b0;
    endtask

    task automatic alloc(input bit hr, input int a, input int p, input int o);
        bus.alloc_valid    = 1'b1;
        bus.alloc_has_rd   = hr;
        bus.alloc_rd_arch  = 5'(a);
        bus.alloc_rd_phys  = 6'(p);
        bus.alloc_old_phys = 6'(o);
    endtask

    task automatic wb(input bit e0, input int i0, input bit e1, input int i1);
        bus.wb_en     = {e1, e0};
        bus.wb_idx[0] = 4'(i0);
        bus.wb_idx[1] = 4'(i1);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        do_reset();
        chk_en = 1'b1;
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_ready", 32'(bus.alloc_ready), 32'd1);
        chk("rst_idx", 32'(bus.alloc_idx), 32'd0);
        chk("rst_cv", 32'(bus.commit_valid), 32'd0);

        // Fill to capacity with nothing completing.
        for (int i = 0; i < RS; i++) begin
            chk("t1_idx", 32'(bus.alloc_idx), 32'(i));
            alloc(1'b1, i + 1, i + 32, i);
            tick();
        end
        idle();
        chk("t1_full", 32'(bus.full), 32'd1);
        chk("t1_ready", 32'(bus.alloc_ready), 32'd0);
        chk("t1_count", 32'(bus.count), 32'd16);
        tick();

        // Full buffer: head completes while rename keeps asking.
        alloc(1'b1, 7, 50, 51);
        wb(1'b1, 0, 1'b0, 0);
        #1;
        chk("t3_ready_full", 32'(bus.alloc_ready), 32'd0);
        tick();
        wb(1'b0, 0, 1'b0, 0);
        #1;
        chk("t3_count_a", 32'(bus.count), 32'd16);
        chk("t3_cv", 32'(bus.commit_valid), 32'd1);
        tick();
        chk("t3_count_b", 32'(bus.count), 32'd15);
        chk("t3_ready", 32'(bus.alloc_ready), 32'd1);
        tick();
        chk("t3_count_c", 32'(bus.count), 32'd16);
        idle();

        // Two ports finish out of order in one cycle.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc(1'b1, i + 3, i + 20, i + 10);
            tick();
        end
        idle();
        wb(1'b1, 1, 1'b1, 0);
        tick();
        wb(1'b0, 0, 1'b0, 0);
        #1;
        chk("t2_cv", 32'(bus.commit_valid), 32'd3);
        chk("t2_idx0", 32'(bus.commit_idx[0]), 32'd0);
        chk("t2_idx1", 32'(bus.commit_idx[1]), 32'd1);
        chk("t2_free0", 32'(bus.free_phys[0]), 32'd10);
        chk("t2_free1", 32'(bus.free_phys[1]), 32'd11);
        chk("t2_phys1", 32'(bus.commit_rd_phys[1]), 32'd21);
        tick();
        chk("t2_stop", 32'(bus.commit_valid), 32'd0);
        chk("t2_count", 32'(bus.count), 32'd2);
        wb(1'b1, 2, 1'b1, 3);
        tick();
        wb(1'b0, 0, 1'b0, 0);
        tick();
        chk("t2_empty", 32'(bus.empty), 32'd1);

        // Stream 14 through to park head at 14, then straddle the wrap.
        do_reset();
        for (int k = 0; k < 14; k++) begin
            alloc(1'b1, k, k + 1, k + 2);
            wb(k > 0, k - 1, 1'b0, 0);
            tick();
        end
        idle();
        wb(1'b1, 13, 1'b0, 0);
        tick();
        idle();
        tick();
        tick();
        tick();
        chk("t4_empty0", 32'(bus.empty), 32'd1);
        chk("t4_head14", 32'(bus.alloc_idx), 32'd14);
        for (int i = 0; i < 4; i++) begin
            chk("t4_aidx", 32'(bus.alloc_idx), 32'((14 + i) % RS));
            alloc(1'b0, 0, i + 40, i + 60);
            tick();
        end
        idle();
        wb(1'b1, 14, 1'b1, 15);
        tick();
        wb(1'b1, 0, 1'b1, 1);
        #1;
        chk("t4_cv_a", 32'(bus.commit_valid), 32'd3);
        chk("t4_ci_a0", 32'(bus.commit_idx[0]), 32'd14);
        chk("t4_ci_a1", 32'(bus.commit_idx[1]), 32'd15);
        tick();
        wb(1'b0, 0, 1'b0, 0);
        #1;
        chk("t4_cv_b", 32'(bus.commit_valid), 32'd3);
        chk("t4_ci_b0", 32'(bus.commit_idx[0]), 32'd0);
        chk("t4_ci_b1", 32'(bus.commit_idx[1]), 32'd1);
        chk("t4_free_b1", 32'(bus.free_phys[1]), 32'd63);
        tick();
        chk("t4_empty", 32'(bus.empty), 32'd1);

        // Mispredict rollback, stale writeback, flush to head.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            alloc(1'b1, i, i + 8, i + 16);
            tick();
        end
        idle();
        bus.flush     = 1'b1;
        bus.flush_idx = 4'd3;
        #1;
        chk("t5_cv_flush", 32'(bus.commit_valid), 32'd0);
        tick();
        idle();
        chk("t5_count", 32'(bus.count), 32'd3);
        chk("t5_tail", 32'(bus.alloc_idx), 32'd3);
        wb(1'b1, 4, 1'b0, 0);
        tick();
        idle();
        tick();
        chk("t5_count_b", 32'(bus.count), 32'd3);
        chk("t5_aidx", 32'(bus.alloc_idx), 32'd3);
        alloc(1'b1, 9, 9, 9);
        tick();
        idle();
        chk("t5_count_c", 32'(bus.count), 32'd4);
        bus.flush     = 1'b1;
        bus.flush_idx = 4'd0;
        tick();
        idle();
        chk("t5_empty", 32'(bus.empty), 32'd1);
        chk("t5_aidx0", 32'(bus.alloc_idx), 32'd0);

        // Stall, no-destination retirement, reset mid-stream.
        do_reset();
        alloc(1'b0, 0, 5, 6);
        tick();
        alloc(1'b1, 4, 7, 8);
        tick();
        idle();
        wb(1'b1, 0, 1'b1, 1);
        tick();
        idle();
        bus.commit_stall = 1'b1;
        #1;
        chk("t6_stall_a", 32'(bus.commit_valid), 32'd0);
        tick();
        chk("t6_stall_b", 32'(bus.commit_valid), 32'd0);
        chk("t6_count", 32'(bus.count), 32'd2);
        bus.commit_stall = 1'b0;
        #1;
        chk("t6_cv", 32'(bus.commit_valid), 32'd3);
        chk("t6_hasrd0", 32'(bus.commit_has_rd[0]), 32'd0);
        chk("t6_hasrd1", 32'(bus.commit_has_rd[1]), 32'd1);
        tick();
        alloc(1'b1, 1, 2, 3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        chk("t6_rst_count", 32'(bus.count), 32'd0);
        chk("t6_rst_empty", 32'(bus.empty), 32'd1);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
